// File: rtl/ram_param_clr.sv
// Parameterised RAM with one valid bit per entry and a sequential clear engine.
// The clear runs after reset and on a flush pulse; the read port is combinational or registered.
module ram_param_clr #(
    parameter int unsigned DW     = 24,
    parameter int unsigned AW     = 3,
    parameter bit          RD_REG = 1'b0
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic [AW-1:0] address,
    input  logic [DW-1:0] data,
    input  logic          we,
    input  logic          flush,
    output logic [DW-1:0] q,
    output logic          valid,
    output logic          busy
);

    localparam int unsigned N = 2 ** AW;

    typedef enum logic {StIdle, StClear} state_e;

    state_e          state_q;
    logic [AW-1:0]   cnt_q;
    logic [N-1:0]    vbit_q;
    logic [DW-1:0]   mem [N];
    logic [DW-1:0]   rd_data;
    logic            rd_valid;

    // Reset parks the engine in StClear so every word is zeroed after release.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= StClear;
            cnt_q   <= '0;
            vbit_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (flush) begin
                        state_q <= StClear;
                        cnt_q   <= '0;
                    end else if (we) begin
                        vbit_q[address] <= 1'b1;
                    end
                end
                StClear: begin
                    vbit_q[cnt_q] <= 1'b0;
                    cnt_q         <= cnt_q + 1'b1;
                    if (cnt_q == AW'(N - 1)) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StClear;
            endcase
        end
    end

    // Storage has no reset; the clear engine is the only way words return to zero.
    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            mem[cnt_q] <= '0;
        end else if (we && !flush) begin
            mem[address] <= data;
        end
    end

    assign busy     = (state_q == StClear);
    assign rd_data  = mem[address];
    assign rd_valid = vbit_q[address] & ~busy;

    if (RD_REG) begin : g_rd_reg
        logic [DW-1:0] q_q;
        logic          valid_q;

        always_ff @(posedge clk or negedge clrn) begin
            if (!clrn) begin
                q_q     <= '0;
                valid_q <= 1'b0;
            end else begin
                q_q     <= rd_data;
                valid_q <= rd_valid;
            end
        end

        assign q     = q_q;
        assign valid = valid_q;
    end else begin : g_rd_comb
        assign q     = rd_data;
        assign valid = rd_valid;
    end

endmodule

// File: tb/tb_ram_param_clr.sv
// Bench for ram_param_clr: combinational and registered-read instances share one stimulus
// stream and are checked against an array model of the storage, valid bits and clear timing.
module tb_ram_param_clr;

    localparam int DW = 24;
    localparam int AW = 3;
    localparam int N  = 8;

    logic          clk = 1'b0;
    logic          clrn = 1'b0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] data = '0;
    logic          we = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] q0, q1;
    logic          v0, v1, b0, b1;

    int ncmp = 0;
    int nfail = 0;

    // Reference model state
    logic [DW-1:0] m_mem [N];
    bit            m_known [N];
    bit            m_vb [N];
    int            m_clr_left;
    int            m_clr_idx;
    logic [DW-1:0] m_rq;
    bit            m_rknown;
    bit            m_rv;

    ram_param_clr #(.DW(DW), .AW(AW), .RD_REG(1'b0)) u_comb (
        .clk(clk), .clrn(clrn), .address(address), .data(data), .we(we), .flush(flush),
        .q(q0), .valid(v0), .busy(b0)
    );

    ram_param_clr #(.DW(DW), .AW(AW), .RD_REG(1'b1)) u_reg (
        .clk(clk), .clrn(clrn), .address(address), .data(data), .we(we), .flush(flush),
        .q(q1), .valid(v1), .busy(b1)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_vb[i] = 1'b0;
        m_clr_left = N;
        m_clr_idx  = 0;
        m_rq       = '0;
        m_rknown   = 1'b1;
        m_rv       = 1'b0;
    endtask

    task automatic model_edge();
        logic [DW-1:0] nq;
        bit            nk, nv;
        if (!clrn) begin
            m_mem[0] = '0;  // engine sits on entry 0 while held in reset
            m_rq     = '0;
            m_rknown = 1'b1;
            m_rv     = 1'b0;
            return;
        end
        nq = m_mem[address];
        nk = m_known[address];
        nv = m_vb[address] && (m_clr_left == 0);
        if (m_clr_left > 0) begin
            m_mem[m_clr_idx]   = '0;
            m_known[m_clr_idx] = 1'b1;
            m_vb[m_clr_idx]    = 1'b0;
            m_clr_idx          = (m_clr_idx + 1) % N;
            m_clr_left--;
        end else if (flush) begin
            m_clr_left = N;
            m_clr_idx  = 0;
        end else if (we) begin
            m_mem[address]   = data;
            m_known[address] = 1'b1;
            m_vb[address]    = 1'b1;
        end
        m_rq     = nq;
        m_rknown = nk;
        m_rv     = nv;
    endtask

    task automatic chk();
        bit exp_busy;
        exp_busy = (m_clr_left != 0);
        cmp("busy_comb", 32'(b0), 32'(exp_busy));
        cmp("busy_reg", 32'(b1), 32'(exp_busy));
        cmp("valid_comb", 32'(v0), 32'(m_vb[address] && !exp_busy));
        if (m_known[address]) cmp("q_comb", 32'(q0), 32'(m_mem[address]));
        cmp("valid_reg", 32'(v1), 32'(m_rv));
        if (m_rknown) cmp("q_reg", 32'(q1), 32'(m_rq));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk();
    endtask

    task automatic count_busy(input string tag);
        int n = 0;
        for (int i = 0; i < 20 && b0; i++) begin
            tick();
            n++;
        end
        cmp(tag, 32'(n), 32'(N));
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            m_mem[i]   = '0;
            m_known[i] = 1'b0;
        end
        model_reset();

        // Reset and the initial clear
        tick();
        tick();
        cmp("rst_busy", 32'(b0), 32'd1);
        cmp("rst_valid_reg", 32'(v1), 32'd0);
        cmp("rst_q_reg", 32'(q1), 32'd0);
        clrn = 1'b1;
        #1 chk();
        count_busy("init_clear_len");
        for (int a = 0; a < N; a++) begin
            address = AW'(a);
            #1 chk();
            cmp("init_q_zero", 32'(q0), 32'h0);
            cmp("init_valid_zero", 32'(v0), 32'd0);
        end
        @(negedge clk);

        // Plain write, then a neighbour read
        address = 3'd5; data = 24'hABCDEF; we = 1'b1;
        tick();
        we = 1'b0;
        cmp("wr5_q", 32'(q0), 32'h00ABCDEF);
        cmp("wr5_valid", 32'(v0), 32'd1);
        address = 3'd4;
        #1 chk();
        cmp("addr4_valid", 32'(v0), 32'd0);
        @(negedge clk);

        // Flush with a simultaneous write, then writes and flushes during the clear
        address = 3'd1; data = 24'h00FF00; we = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0;
        address = 3'd2; data = 24'h123456;
        begin
            int n = 0;
            for (int i = 0; i < 20 && b0; i++) begin
                flush = (i == 3);
                tick();
                n++;
            end
            cmp("flush_clear_len", 32'(n), 32'(N));
        end
        we = 1'b0; flush = 1'b0;
        for (int a = 0; a < N; a++) begin
            address = AW'(a);
            #1 chk();
            cmp("post_flush_q", 32'(q0), 32'h0);
            cmp("post_flush_valid", 32'(v0), 32'd0);
        end
        @(negedge clk);

        // Registered read latency and read-during-write
        address = 3'd7; data = 24'h5A5A5A; we = 1'b1;
        tick();
        we = 1'b0;
        tick();
        cmp("rdreg_q7", 32'(q1), 32'h005A5A5A);
        cmp("rdreg_v7", 32'(v1), 32'd1);
        data = 24'h010203; we = 1'b1;
        tick();
        we = 1'b0;
        cmp("rdreg_old_data", 32'(q1), 32'h005A5A5A);
        tick();
        cmp("rdreg_new_data", 32'(q1), 32'h00010203);

        // Reset pulse in the middle of a clear
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick(); tick(); tick();
        clrn = 1'b0;
        model_reset();
        for (int a = 0; a < N; a++) begin
            address = AW'(a);
            #1 chk();
            cmp("midrst_valid", 32'(v0), 32'd0);
        end
        cmp("midrst_reg_valid", 32'(v1), 32'd0);
        tick();
        tick();
        clrn = 1'b1;
        #1 chk();
        count_busy("midrst_clear_len");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            address = AW'($urandom_range(N - 1));
            data    = DW'($urandom);
            we      = ($urandom_range(2) != 0);
            flush   = ($urandom_range(24) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
